alu_exec_unit: RTL

Execute-stage arithmetic unit of the RV32I core, directly downstream of ALU control. It consumes the 4-bit ALUCon code and two 32-bit operands, and produces a registered 32-bit result plus compare flags for branches. It uses a valid/ready handshake on both sides. Shifts run iteratively, one bit per cycle, unless the fast shifter is compiled in.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_unit.sv | 70 +++++++
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUCon encodings, width and state type for the execute ALU
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_CMP  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [3:0] con);
    return (con == ALU_SLL) || (con == ALU_SRL) || (con == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - one-bit-per-cycle shifter, or barrel shifter when ALU_FAST_SHIFT_EN is defined
module alu_shift_unit
  import alu_pkg::*;
(
`ifndef ALU_FAST_SHIFT_EN
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  output logic            done_o,
`endif
  input  logic [3:0]      con_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [4:0]      shamt_i,
  output logic [XLEN-1:0] result_o
);

`ifdef ALU_FAST_SHIFT_EN

  // Single-cycle barrel shift straight from the presented operands
  always_comb begin
    result_o = a_i;
    case (con_i)
      ALU_SLL: result_o = a_i << shamt_i;
      ALU_SRL: result_o = a_i >> shamt_i;
      ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt_i);
      default: result_o = a_i;
    endcase
  end

`else

  logic [XLEN-1:0] shreg_q;
  logic [4:0]      cnt_q;
  logic [3:0]      con_q;
  logic [XLEN-1:0] step_d;

  // One-bit step of the held value; arithmetic right keeps bit 31, which is the original sign
  always_comb begin
    step_d = shreg_q;
    case (con_q)
      ALU_SLL: step_d = {shreg_q[XLEN-2:0], 1'b0};
      ALU_SRL: step_d = {1'b0, shreg_q[XLEN-1:1]};
      default: step_d = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    endcase
  end

  // Load on start, then shift and count down until the counter empties
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      con_q   <= ALU_SLL;
    end else if (load_i) begin
      shreg_q <= a_i;
      cnt_q   <= shamt_i;
      con_q   <= con_i;
    end else if (cnt_q != 5'd0) begin
      shreg_q <= step_d;
      cnt_q   <= cnt_q - 5'd1;
    end
  end

  // Last step: the value after this edge's shift is the final result
  assign done_o   = (cnt_q == 5'd1);
  assign result_o = step_d;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and branch flags (option: ALU_FAST_SHIFT_EN)
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_con,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q;
  logic            zero_q, lt_q, ltu_q;
  logic            accept, lt_in, ltu_in;
  logic [XLEN-1:0] alu_res, sh_result;
  logic            wr_en, wr_lt, wr_ltu;
  logic [XLEN-1:0] wr_res;

  assign lt_in  = $signed(op_a) < $signed(op_b);
  assign ltu_in = op_a < op_b;

`ifdef ALU_FAST_SHIFT_EN

  assign in_ready = rst_n && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  alu_shift_unit u_shift (
    .con_i    (alu_con),
    .a_i      (op_a),
    .shamt_i  (op_b[4:0]),
    .result_o (sh_result)
  );

  // Every op, shifts included, lands in the output register at accept
  always_comb begin
    wr_en  = accept;
    wr_res = alu_res;
    wr_lt  = lt_in;
    wr_ltu = ltu_in;
  end

`else

  state_e state_q, state_d;
  logic   start_shift, sh_done;
  logic   lt_p_q, ltu_p_q;

  assign in_ready    = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign start_shift = accept && is_shift(alu_con) && (op_b[4:0] != 5'd0);

  alu_shift_unit u_shift (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (flush),
    .load_i   (start_shift),
    .done_o   (sh_done),
    .con_i    (alu_con),
    .a_i      (op_a),
    .shamt_i  (op_b[4:0]),
    .result_o (sh_result)
  );

  // Output write comes from an immediate accept or from the last shift step
  always_comb begin
    wr_en   = accept && !start_shift;
    wr_res  = alu_res;
    wr_lt   = lt_in;
    wr_ltu  = ltu_in;
    state_d = state_q;
    if (start_shift) begin
      state_d = SHIFT;
    end
    if ((state_q == SHIFT) && sh_done) begin
      wr_en   = 1'b1;
      wr_res  = sh_result;
      wr_lt   = lt_p_q;
      wr_ltu  = ltu_p_q;
      state_d = IDLE;
    end
  end

  // FSM state and flags captured at accept for the shift still running
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q <= IDLE;
      lt_p_q  <= 1'b0;
      ltu_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_shift) begin
        lt_p_q  <= lt_in;
        ltu_p_q <= ltu_in;
      end
    end
  end

`endif

  // Result mux; a zero-amount shift in the iterative build is just op_a
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_con)
      ALU_SUB, ALU_CMP: alu_res = op_a - op_b;
      ALU_XOR:          alu_res = op_a ^ op_b;
      ALU_OR:           alu_res = op_a | op_b;
      ALU_AND:          alu_res = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
        alu_res = sh_result;
`else
        alu_res = op_a;
`endif
      end
      ALU_SLT:          alu_res = {{(XLEN-1){1'b0}}, lt_in};
      ALU_SLTU:         alu_res = {{(XLEN-1){1'b0}}, ltu_in};
      default:          alu_res = op_a + op_b;
    endcase
  end

  assign out_valid_d = wr_en ? 1'b1 : (out_valid_q && !out_ready);

  // Output register: written only when a new result arrives, valid held until drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (wr_en) begin
        result_q <= wr_res;
        zero_q   <= (wr_res == '0);
        lt_q     <= wr_lt;
        ltu_q    <= wr_ltu;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;

endmodule
